me_scan_addr_gen: RTL and testbench
===================================

ME_SCAN_ADDR_GEN -- requirements
Module: me_scan_addr_gen

Interface
REQ-001 The block SHALL have parameter BLK, default 8, meaning template-block edge in pixels (TB holds BLK*BLK pixels, row-major).
REQ-002 The block SHALL have parameter SW, default 32, meaning search-window edge in pixels (SW holds SW*SW pixels, row-major).
REQ-003 The block SHALL have parameter STEP, default 4, meaning candidate displacement stride in pixels on both axes.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-006 The block SHALL have port clr, input, 1, meaning synchronous abort to IDLE.
REQ-007 The block SHALL have port start, input, 1, meaning begin a full search scan.
REQ-008 The block SHALL have port en, input, 1, meaning advance enable (0 = stall).
REQ-009 The block SHALL have port addr_sw, output, SW_AW = clog2(SW*SW), meaning search-window pixel address.
REQ-010 The block SHALL have port addr_tb, output, TB_AW = clog2(BLK*BLK), meaning template pixel address.
REQ-011 The block SHALL have port cand_x and port cand_y, output, CW = clog2(SW-BLK+1) each, meaning current candidate displacement.
REQ-012 The block SHALL have port valid, output, 1, meaning addresses valid (state RUN).
REQ-013 The block SHALL have port cand_last, output, 1, meaning current pixel is the last of the candidate.
REQ-014 The block SHALL have port busy, output, 1, meaning scan in progress (RUN).
REQ-015 The block SHALL have port done, output, 1, meaning one-cycle pulse after the final pixel.

Function
REQ-016 The block SHALL require (SW-BLK) % STEP == 0 and BLK <= SW, and SHALL flag a violation at elaboration; N = (SW-BLK)/STEP+1 candidates per axis.
REQ-017 The block SHALL implement the states IDLE, RUN and DONE.
REQ-018 IDLE: start=1 SHALL move the block to RUN on the next edge with col=row=cand_x=cand_y=0.
REQ-019 RUN: on each cycle with en=1 the block SHALL step col; when col wraps at BLK-1 it SHALL step row; when row wraps it SHALL step cand_x by STEP; when cand_x wraps at SW-BLK it SHALL step cand_y by STEP.
REQ-020 RUN: en=1 with cand_last=1 and cand_x=cand_y=SW-BLK SHALL cause the transition to DONE.
REQ-021 RUN: en=0 SHALL hold all counters and outputs unchanged.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE; start in DONE SHALL be ignored.
REQ-023 addr_tb SHALL equal row*BLK + col, and addr_sw SHALL equal (cand_y+row)*SW + (cand_x+col), both registered and both matching the current counters in the same cycle.
REQ-024 cand_last SHALL equal valid & (row==BLK-1) & (col==BLK-1).
REQ-025 start while in RUN SHALL be ignored (no restart).
REQ-026 clr SHALL take priority over start and en: from any state it SHALL go to IDLE with all counters cleared and no done pulse.
REQ-027 The block SHALL use no arithmetic that wraps modulo the address width; the maximum addr_sw SHALL be SW*SW-1.
REQ-028 With en held at 1, a full scan SHALL take N*N*BLK*BLK RUN cycles plus one DONE cycle.

Reset
REQ-029 rst_n=0 sampled at a clk edge SHALL force IDLE, all counters 0, and addr_sw=0, addr_tb=0, cand_x=0, cand_y=0, valid=0, cand_last=0, busy=0, done=0.
REQ-030 Reset asserted mid-scan SHALL abort the scan without a done pulse; the first post-reset scan SHALL behave identically to a cold start.

Structure
REQ-031 The shared package me_pkg SHALL hold the state encoding, the clog2 helper and the derived widths SW_AW, TB_AW and CW.
REQ-032 A sub-module me_wrap_cnt (parameters MAX and INC; ports clk, rst_n, clr, inc, value, wrap) SHALL be instantiated for col, row, cand_x and cand_y, chained through wrap.

Verification
REQ-033 Defaults, start pulse, en=1 -> first valid cycle shows addr_sw=0, addr_tb=0; the 64th valid cycle shows addr_sw=231, addr_tb=63, cand_last=1.
REQ-034 Defaults, continue -> the second candidate starts with cand_x=4, addr_sw=4; the candidate after cand_x=24 shows cand_x=0, cand_y=4, addr_sw=128.
REQ-035 Defaults, full run with en=1 -> done pulses once after 3136 valid cycles; the last address is addr_sw=1023; then IDLE with busy=0.
REQ-036 Random en stalls -> the address sequence equals the no-stall sequence with the values held during stalls; total en=1 cycles = 3136.
REQ-037 clr and start together, and clr mid-scan -> the block is in IDLE the next cycle with all outputs 0 and no done; rst_n=0 mid-scan gives the same result.
REQ-038 BLK=4, SW=8, STEP=2 -> N=3, 144 valid cycles; the last addr_sw is 63.

Source files
------------

// File: rtl/me_scan_addr_gen_pkg.sv
// Shared types and width helpers for the motion-estimation scan address generator.
package me_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Width needed to index n distinct values, never narrower than one bit.
  function automatic int unsigned wid(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

  localparam int unsigned SW_AW = wid(32 * 32);
  localparam int unsigned TB_AW = wid(8 * 8);
  localparam int unsigned CW    = wid(32 - 8 + 1);

endpackage

// File: rtl/me_scan_addr_gen_wrap_cnt.sv
// Wrapping up-counter: steps by INC on inc, returns to zero after MAX and flags wrap.
module me_wrap_cnt
  import me_pkg::*;
#(
  parameter int unsigned MAX = 7,
  parameter int unsigned INC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  output logic [wid(MAX+1)-1:0]   value,
  output logic                    wrap
);

  localparam int unsigned W = wid(MAX + 1);

  assign wrap = inc && (value == W'(MAX));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : W'(value + INC);
    end
  end

endmodule

// File: rtl/me_scan_addr_gen.sv
// Full-search scan address generator: walks every template pixel of every candidate
// displacement and emits registered template and search-window addresses.
module me_scan_addr_gen
  import me_pkg::*;
#(
  parameter int unsigned BLK  = 8,
  parameter int unsigned SW   = 32,
  parameter int unsigned STEP = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         start,
  input  logic                         en,
  output logic [wid(SW*SW)-1:0]        addr_sw,
  output logic [wid(BLK*BLK)-1:0]      addr_tb,
  output logic [wid(SW-BLK+1)-1:0]     cand_x,
  output logic [wid(SW-BLK+1)-1:0]     cand_y,
  output logic                         valid,
  output logic                         cand_last,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned A_SW = wid(SW * SW);
  localparam int unsigned A_TB = wid(BLK * BLK);
  localparam int unsigned A_PX = wid(BLK);

  if (STEP == 0) begin : g_bad_step
    $error("me_scan_addr_gen: STEP must be non-zero");
  end else if (BLK > SW || ((SW - BLK) % STEP) != 0) begin : g_bad_geom
    $error("me_scan_addr_gen: need BLK <= SW and (SW-BLK) divisible by STEP");
  end

  state_t state, state_nx;

  logic [A_PX-1:0] col, row;
  logic            col_inc, col_wrap, row_wrap, cx_wrap, cy_wrap;

  assign col_inc = valid && en;

  me_wrap_cnt #(.MAX(BLK - 1), .INC(1)) u_col (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(col_inc), .value(col), .wrap(col_wrap)
  );
  me_wrap_cnt #(.MAX(BLK - 1), .INC(1)) u_row (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(col_wrap), .value(row), .wrap(row_wrap)
  );
  me_wrap_cnt #(.MAX(SW - BLK), .INC(STEP)) u_cx (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(row_wrap), .value(cand_x), .wrap(cx_wrap)
  );
  me_wrap_cnt #(.MAX(SW - BLK), .INC(STEP)) u_cy (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(cx_wrap), .value(cand_y), .wrap(cy_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clr) state <= ST_IDLE;
    else               state <= state_nx;
  end

  // cy_wrap fires only on the final pixel of the final candidate with en high.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start)   state_nx = ST_RUN;
      ST_RUN:  if (cy_wrap) state_nx = ST_DONE;
      ST_DONE:              state_nx = ST_IDLE;
      default:              state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    valid     = (state == ST_RUN);
    busy      = (state == ST_RUN);
    done      = (state == ST_DONE);
    cand_last = valid && (row == A_PX'(BLK - 1)) && (col == A_PX'(BLK - 1));
  end

  // Addresses are registered from the counters' next values so they line up
  // with the counter outputs in the same cycle; arithmetic is done at 32 bits.
  int unsigned col_n, row_n, cx_n, cy_n, tb_n, sw_n;

  always_comb begin
    col_n = col_wrap ? 0 : (col_inc   ? int'(col) + 1       : int'(col));
    row_n = row_wrap ? 0 : (col_wrap  ? int'(row) + 1       : int'(row));
    cx_n  = cx_wrap  ? 0 : (row_wrap  ? int'(cand_x) + STEP : int'(cand_x));
    cy_n  = cy_wrap  ? 0 : (cx_wrap   ? int'(cand_y) + STEP : int'(cand_y));
    tb_n  = row_n * BLK + col_n;
    sw_n  = (cy_n + row_n) * SW + cx_n + col_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      addr_tb <= '0;
      addr_sw <= '0;
    end else begin
      addr_tb <= A_TB'(tb_n);
      addr_sw <= A_SW'(sw_n);
    end
  end

endmodule

// File: tb/tb_me_scan_addr_gen.sv
// Self-checking bench: two configurations scanned against a nested-loop reference.
module tb_me_scan_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [2];
  logic clr   [2];
  logic start [2];
  logic en    [2];

  logic [9:0] sw0;
  logic [5:0] tb0;
  logic [4:0] cx0, cy0;
  logic       v0, l0, b0, d0;

  logic [5:0] sw1;
  logic [3:0] tb1;
  logic [2:0] cx1, cy1;
  logic       v1, l1, b1, d1;

  me_scan_addr_gen u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .clr(clr[0]), .start(start[0]), .en(en[0]),
    .addr_sw(sw0), .addr_tb(tb0), .cand_x(cx0), .cand_y(cy0),
    .valid(v0), .cand_last(l0), .busy(b0), .done(d0)
  );

  me_scan_addr_gen #(.BLK(4), .SW(8), .STEP(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .clr(clr[1]), .start(start[1]), .en(en[1]),
    .addr_sw(sw1), .addr_tb(tb1), .cand_x(cx1), .cand_y(cy1),
    .valid(v1), .cand_last(l1), .busy(b1), .done(d1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned sw, tb, cx, cy;
    int unsigned last;
  } pix_t;
  pix_t expq[$];

  int unsigned o_sw, o_tb, o_cx, o_cy, o_v, o_l, o_b, o_d;

  task automatic sample(input int sel);
    if (sel == 0) begin
      o_sw = sw0; o_tb = tb0; o_cx = cx0; o_cy = cy0;
      o_v = v0; o_l = l0; o_b = b0; o_d = d0;
    end else begin
      o_sw = sw1; o_tb = tb1; o_cx = cx1; o_cy = cy1;
      o_v = v1; o_l = l1; o_b = b1; o_d = d1;
    end
  endtask

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    sample(sel);
    check({tag, ".valid"},  o_v,  0);
    check({tag, ".last"},   o_l,  0);
    check({tag, ".busy"},   o_b,  0);
    check({tag, ".done"},   o_d,  0);
    check({tag, ".sw"},     o_sw, 0);
    check({tag, ".tb"},     o_tb, 0);
    check({tag, ".cx"},     o_cx, 0);
    check({tag, ".cy"},     o_cy, 0);
  endtask

  // Reference: candidates in raster order, template pixels row-major in each.
  task automatic build(input int sel);
    int unsigned blk, sw, step;
    pix_t p;
    blk  = (sel == 0) ? 8  : 4;
    sw   = (sel == 0) ? 32 : 8;
    step = (sel == 0) ? 4  : 2;
    expq.delete();
    for (int unsigned cy = 0; cy <= sw - blk; cy += step)
      for (int unsigned cx = 0; cx <= sw - blk; cx += step)
        for (int unsigned r = 0; r < blk; r++)
          for (int unsigned c = 0; c < blk; c++) begin
            p.sw   = (cy + r) * sw + cx + c;
            p.tb   = r * blk + c;
            p.cx   = cx;
            p.cy   = cy;
            p.last = (r == blk - 1 && c == blk - 1) ? 1 : 0;
            expq.push_back(p);
          end
  endtask

  task automatic run_scan(input int sel, input bit stall, input string tag);
    int unsigned idx, cyc, total, e;
    build(sel);
    total = (sel == 0) ? 3136 : 144;
    check({tag, ".model_len"}, expq.size(), total);
    @(negedge clk);
    start[sel] = 1'b1;
    en[sel]    = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < expq.size() && cyc < 20000) begin
      @(negedge clk);
      sample(sel);
      check({tag, ".valid"}, o_v,  1);
      check({tag, ".busy"},  o_b,  1);
      check({tag, ".done"},  o_d,  0);
      check({tag, ".sw"},    o_sw, expq[idx].sw);
      check({tag, ".tb"},    o_tb, expq[idx].tb);
      check({tag, ".cx"},    o_cx, expq[idx].cx);
      check({tag, ".cy"},    o_cy, expq[idx].cy);
      check({tag, ".last"},  o_l,  expq[idx].last);
      e = stall ? (($urandom_range(0, 3) != 0) ? 1 : 0) : 1;
      en[sel]    = e[0];
      start[sel] = ($urandom_range(0, 7) == 0);
      if (e != 0) idx++;
      cyc++;
    end
    check({tag, ".en_cycles"}, idx, total);
    @(negedge clk);
    sample(sel);
    check({tag, ".done_pulse"}, o_d, 1);
    check({tag, ".done_valid"}, o_v, 0);
    check({tag, ".done_busy"},  o_b, 0);
    start[sel] = 1'b1;
    en[sel]    = 1'b0;
    @(negedge clk);
    check_idle(sel, {tag, ".after_done"});
    start[sel] = 1'b0;
    @(negedge clk);
    check_idle(sel, {tag, ".start_in_done_ignored"});
  endtask

  // kind 0: clr mid-scan, 1: rst_n mid-scan, 2: clr with start mid-scan
  task automatic abort_scan(input int sel, input int kind, input string tag);
    @(negedge clk);
    start[sel] = 1'b1;
    en[sel]    = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    repeat (70) @(negedge clk);
    sample(sel);
    check({tag, ".running"}, o_b, 1);
    if (kind == 1) rst_n[sel] = 1'b0;
    else           clr[sel]   = 1'b1;
    if (kind == 2) start[sel] = 1'b1;
    @(negedge clk);
    rst_n[sel] = 1'b1;
    clr[sel]   = 1'b0;
    start[sel] = 1'b0;
    check_idle(sel, {tag, ".cycle1"});
    @(negedge clk);
    check_idle(sel, {tag, ".cycle2"});
    en[sel] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; clr[i] = 1'b0; start[i] = 1'b0; en[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    run_scan(0, 1'b0, "full0");
    run_scan(0, 1'b1, "stall0");

    clr[0]   = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    clr[0]   = 1'b0;
    start[0] = 1'b0;
    check_idle(0, "clr_start_idle");
    @(negedge clk);
    check_idle(0, "clr_start_idle2");

    abort_scan(0, 0, "clr_mid");
    abort_scan(0, 2, "clr_start_mid");
    abort_scan(0, 1, "rst_mid");
    run_scan(0, 1'b0, "post_reset0");

    run_scan(1, 1'b0, "full1");
    run_scan(1, 1'b1, "stall1");
    abort_scan(1, 1, "rst_mid1");
    run_scan(1, 1'b1, "post_reset1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
